hd_err_monitor: RTL
===================

// Module: hd_err_monitor
// PURPOSE
//  Streaming downstream consumer for the max-Hamming-distance miter. Per sample: takes exact/approx output words, computes HD = popcount(exact^approx), flags HD > MHD.
//  Accumulates run statistics for error-metric checking of approximate circuits:
//   violation count, max HD, HD sum. One pass/fail verdict per run of num_samples.
// PARAMETERS
//  WIDTH  16  operand width (bits)
//  MHD    2   max allowed Hamming distance; HD > MHD is a violation
//  CNT_W  32  width of sample/violation counters and HD-sum accumulator
//  HD_W   localparam = $clog2(WIDTH+1), popcount width (5 for WIDTH=16)
// PORTS
//  clk          in   1      rising-edge clock
//  rst_n        in   1      async active-low reset
//  start        in   1      1-cycle pulse; begins a run; ignored unless IDLE
//  num_samples  in   CNT_W  samples in run; latched when start is accepted
//  in_valid     in   1      sample valid
//  in_ready     out  1      block accepts sample (valid&&ready = transfer)
//  in_exact     in   WIDTH  golden output word
//  in_approx    in   WIDTH  approximate output word
//  busy         out  1      high from accepted start until done pulse (inclusive)
//  done         out  1      1-cycle pulse; statistics final and stable
//  pass         out  1      err_cnt==0; valid when done, held until next start
//  err_cnt      out  CNT_W  number of samples with HD > MHD (saturating)
//  max_hd       out  HD_W   largest HD seen this run
//  hd_sum       out  CNT_W  sum of HD over run (saturating)
// BEHAVIOUR
//  Reset: state IDLE; in_ready, busy, done, pass, err_cnt, max_hd, hd_sum = 0.
//  FSM: IDLE -start-> RUN (num_samples>0) or DRAIN (num_samples==0);
//   RUN -last sample accepted-> DRAIN; DRAIN -pipe empty-> DONE; DONE -> IDLE (1 cycle).
//  start accepted in IDLE: clears err_cnt/max_hd/hd_sum/pass, zeroes accept counter.
//  in_ready = (state==RUN) && (accepted < num_samples); combinational from state, never from in_valid.
//  Pipeline: S1 registers HD of transfer at cycle t (valid bit + HD); S2 updates stats at t+1.
//   Stats visible 2 cycles after transfer. No backpressure inside; in_ready alone throttles.
//  DRAIN exits when both S1 and S2 valid bits are 0; done asserts in DONE cycle; pass=(err_cnt==0).
//  num_samples==0: done 2 cycles after start, pass=1, all stats 0.
//  Saturation: err_cnt, hd_sum clamp at 2^CNT_W-1; max_hd cannot overflow (HD<=WIDTH).
//  HD==MHD is not a violation; only strictly greater counts.
//  start while not IDLE ignored; in_valid outside RUN ignored (no transfer).
//  rst_n low mid-run: immediate abort to reset values; no done pulse.
// CONFIGURATION
//  FIRST_FAIL_CAPTURE_EN defined: extra outputs ff_valid(1), ff_idx(CNT_W), ff_hd(HD_W);
//   capture 0-based sample index + HD of first violation; cleared on start/reset; held after done.
//  Undefined: ports and logic absent; all other behaviour identical.
// STRUCTURE
//  Package hd_mon_pkg: state typedef enum {IDLE,RUN,DRAIN,DONE}; function hd_w(width) for HD_W.
//  Sub-module hd_popcount: WIDTH in, HD_W out, registered (S1 stage), valid in/out.
//  Top: FSM, accept counter, S2 accumulators, optional first-fail capture.
// TESTING
//  1. start, N=4, exact=approx each sample -> done, pass=1, err_cnt=0, max_hd=0, hd_sum=0.
//  2. N=3, XOR diffs 0x0003,0x0007,0xFFFF -> err_cnt=2, max_hd=16, hd_sum=21, pass=0.
//  3. N=0 -> done exactly 2 cycles after start, pass=1; in_ready never high.
//  4. N=5, in_valid toggled randomly -> exactly 5 transfers; in_ready low after 5th; done after drain.
//  5. Reset asserted mid-RUN after 2 samples -> all outputs 0 next edge, no done; new run is clean.
//  6. FIRST_FAIL_CAPTURE_EN, diffs HD 1,2,3,5 -> ff_valid=1, ff_idx=2, ff_hd=3.

Source files
------------

// File: rtl/hd_mon_pkg.sv
// ---------------------------------------------------------------------------
// hd_mon_pkg
//   Shared types and helpers for the Hamming-distance error monitor.
//   - state_t : run-control FSM states.
//   - hd_w()  : width needed to hold a popcount of a WIDTH-bit word.
// ---------------------------------------------------------------------------
package hd_mon_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // A popcount of WIDTH bits ranges over 0..WIDTH, hence WIDTH+1 values.
    function automatic int hd_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/hd_popcount.sv
// ---------------------------------------------------------------------------
// hd_popcount
//   Registered popcount stage (S1 of the monitor pipeline). Counts the set
//   bits of in_word and registers the count together with a valid bit.
// Ports:
//   clk        in  rising-edge clock
//   rst_n      in  async active-low reset
//   in_valid   in  in_word carries a sample this cycle
//   in_word    in  WIDTH-bit difference word (exact ^ approx)
//   out_valid  out registered in_valid
//   out_hd     out registered popcount of in_word (HD_W bits)
// ---------------------------------------------------------------------------
module hd_popcount
    import hd_mon_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int HD_W  = hd_w(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_word,
    output logic             out_valid,
    output logic [HD_W-1:0]  out_hd
);

    logic            valid_q;
    logic            valid_d;
    logic [HD_W-1:0] hd_q;
    logic [HD_W-1:0] hd_d;

    always_comb begin
        valid_d = in_valid;
        hd_d    = hd_q;
        // Only load a new count on a real sample so the register does not
        // toggle on idle cycles.
        if (in_valid) begin
            hd_d = '0;
            for (int i = 0; i < WIDTH; i++) begin
                hd_d = hd_d + HD_W'(in_word[i]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            hd_q    <= '0;
        end else begin
            valid_q <= valid_d;
            hd_q    <= hd_d;
        end
    end

    assign out_valid = valid_q;
    assign out_hd    = hd_q;

endmodule

// File: rtl/hd_err_monitor.sv
// ---------------------------------------------------------------------------
// hd_err_monitor
//   Streaming consumer for a max-Hamming-distance miter. For each accepted
//   sample it computes HD = popcount(exact ^ approx) and flags HD > MHD.
//   Over a run of num_samples it accumulates violation count, maximum HD
//   and HD sum, then pulses done with a pass verdict (no violations).
//
//   Pipeline: transfer at cycle t -> S1 (popcount register) -> S2 stats
//   registers; statistics are visible two cycles after the transfer.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   start, num_samples    begin a run (only accepted in IDLE)
//   in_valid/in_ready     sample handshake; in_exact/in_approx data words
//   busy, done, pass      run status; done is a single-cycle pulse
//   err_cnt, max_hd,      run statistics (err_cnt and hd_sum saturate)
//   hd_sum
//
// Optional feature (macro FIRST_FAIL_CAPTURE_EN):
//   ff_valid, ff_idx, ff_hd report the 0-based index and HD of the first
//   violating sample in the run. Absent when the macro is undefined.
// ---------------------------------------------------------------------------
module hd_err_monitor
    import hd_mon_pkg::*;
#(
    parameter  int WIDTH = 16,
    parameter  int MHD   = 2,
    parameter  int CNT_W = 32,
    localparam int HD_W  = hd_w(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_samples,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_exact,
    input  logic [WIDTH-1:0] in_approx,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_cnt,
    output logic [HD_W-1:0]  max_hd,
    output logic [CNT_W-1:0] hd_sum
`ifdef FIRST_FAIL_CAPTURE_EN
    ,
    output logic             ff_valid,
    output logic [CNT_W-1:0] ff_idx,
    output logic [HD_W-1:0]  ff_hd
`endif
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] num_q, num_d;
    logic [CNT_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic [HD_W-1:0]  max_q, max_d;
    logic [CNT_W-1:0] sum_q, sum_d;
    logic             pass_q, pass_d;
    logic             s2_valid_q;
    logic [CNT_W:0]   sum_ext;
    logic             ready;
    logic             xfer;
    logic             s1_valid;
    logic [HD_W-1:0]  s1_hd;
    logic             s1_viol;

`ifdef FIRST_FAIL_CAPTURE_EN
    logic             ff_valid_q, ff_valid_d;
    logic [CNT_W-1:0] ff_idx_q, ff_idx_d;
    logic [HD_W-1:0]  ff_hd_q, ff_hd_d;
    // Samples that have reached S2 so far; gives the index of the one in S2.
    logic [CNT_W-1:0] proc_q, proc_d;
`endif

    // Ready depends only on state and the accept counter, never on in_valid.
    assign ready = (state_q == RUN) && (acc_q < num_q);
    assign xfer  = in_valid && ready;

    hd_popcount #(
        .WIDTH (WIDTH),
        .HD_W  (HD_W)
    ) u_s1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (xfer),
        .in_word   (in_exact ^ in_approx),
        .out_valid (s1_valid),
        .out_hd    (s1_hd)
    );

    assign s1_viol = s1_hd > HD_W'(MHD);

    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        acc_d   = acc_q;
        err_d   = err_q;
        max_d   = max_q;
        sum_d   = sum_q;
        pass_d  = pass_q;
        sum_ext = {1'b0, sum_q} + (CNT_W + 1)'(s1_hd);
`ifdef FIRST_FAIL_CAPTURE_EN
        ff_valid_d = ff_valid_q;
        ff_idx_d   = ff_idx_q;
        ff_hd_d    = ff_hd_q;
        proc_d     = proc_q;
`endif

        // S2: fold the sample leaving S1 into the statistics.
        if (s1_valid) begin
            if (s1_viol && (err_q != '1)) begin
                err_d = err_q + CNT_W'(1);
            end
            if (s1_hd > max_q) begin
                max_d = s1_hd;
            end
            sum_d = sum_ext[CNT_W] ? '1 : sum_ext[CNT_W-1:0];
`ifdef FIRST_FAIL_CAPTURE_EN
            if (s1_viol && !ff_valid_q) begin
                ff_valid_d = 1'b1;
                ff_idx_d   = proc_q;
                ff_hd_d    = s1_hd;
            end
            proc_d = proc_q + CNT_W'(1);
`endif
        end

        case (state_q)
            IDLE: begin
                // The pipeline is empty in IDLE, so clearing here cannot
                // race with an S2 update.
                if (start) begin
                    num_d   = num_samples;
                    acc_d   = '0;
                    err_d   = '0;
                    max_d   = '0;
                    sum_d   = '0;
                    pass_d  = 1'b0;
                    state_d = (num_samples == '0) ? DRAIN : RUN;
`ifdef FIRST_FAIL_CAPTURE_EN
                    ff_valid_d = 1'b0;
                    ff_idx_d   = '0;
                    ff_hd_d    = '0;
                    proc_d     = '0;
`endif
                end
            end
            RUN: begin
                if (xfer) begin
                    acc_d = acc_q + CNT_W'(1);
                    if ((acc_q + CNT_W'(1)) == num_q) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // With both stages empty, err_cnt already holds its final value.
                if (!s1_valid && !s2_valid_q) begin
                    state_d = DONE;
                    pass_d  = (err_q == '0);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            num_q      <= '0;
            acc_q      <= '0;
            err_q      <= '0;
            max_q      <= '0;
            sum_q      <= '0;
            pass_q     <= 1'b0;
            s2_valid_q <= 1'b0;
`ifdef FIRST_FAIL_CAPTURE_EN
            ff_valid_q <= 1'b0;
            ff_idx_q   <= '0;
            ff_hd_q    <= '0;
            proc_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            num_q      <= num_d;
            acc_q      <= acc_d;
            err_q      <= err_d;
            max_q      <= max_d;
            sum_q      <= sum_d;
            pass_q     <= pass_d;
            s2_valid_q <= s1_valid;
`ifdef FIRST_FAIL_CAPTURE_EN
            ff_valid_q <= ff_valid_d;
            ff_idx_q   <= ff_idx_d;
            ff_hd_q    <= ff_hd_d;
            proc_q     <= proc_d;
`endif
        end
    end

    assign in_ready = ready;
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign pass     = pass_q;
    assign err_cnt  = err_q;
    assign max_hd   = max_q;
    assign hd_sum   = sum_q;
`ifdef FIRST_FAIL_CAPTURE_EN
    assign ff_valid = ff_valid_q;
    assign ff_idx   = ff_idx_q;
    assign ff_hd    = ff_hd_q;
`endif

endmodule
